// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  localparam logic [3:0] REG_PC     = 4'd15;
  localparam int         WAIT_CNT_W = 8;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-unit bus: pipeline status in, stall/flush/forward controls out.
interface pipe_hazard_ctrl_if;

  logic [3:0] RA1D, RA2D, RA1E, RA2E;
  logic [3:0] WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic       BranchTakenE, MemReqM, MemReadyM;

  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW;
  logic       MemErr;

  // Pipeline datapath side.
  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output RegWriteM, RegWriteW, MemtoRegE,
    output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemErr
  );

  // Hazard controller side.
  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  RegWriteM, RegWriteW, MemtoRegE,
    input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemErr
  );

endinterface

// File: rtl/hazard_fwd_unit.sv
// E-stage operand forwarding select for one source operand; M beats W, R15 never forwarded.
module hazard_fwd_unit
  import pipe_hazard_pkg::*;
(
  input  logic [3:0] ra_e,
  input  logic [3:0] wa_m,
  input  logic [3:0] wa_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output fwd_sel_t   sel
);

  // NOTE: default assigned first so no path through the block can infer a latch.
  always_comb begin
    sel = FWD_RF;
    if (ra_e != REG_PC) begin
      if (reg_write_m && (ra_e == wa_m))      sel = FWD_M;
      else if (reg_write_w && (ra_e == wa_w)) sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller with memory-wait FSM and timeout watchdog.
// Optional macro PIPE_HAZARD_PERF_EN adds saturating StallCycles/FlushCount counters.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic clk,
  input  logic reset,
  pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
`endif
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  hz_state_t             state, state_n;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_n;
  logic                  mem_err, mem_err_n;
  fwd_sel_t              fwd_a, fwd_b;
  logic                  lds, pcp, kill_lds;
  logic                  stall_f, stall_d, stall_e, stall_m;
  logic                  flush_d, flush_e, flush_w;

  hazard_fwd_unit u_fwd_a (
    .ra_e(hz.RA1E), .wa_m(hz.WA3M), .wa_w(hz.WA3W),
    .reg_write_m(hz.RegWriteM), .reg_write_w(hz.RegWriteW), .sel(fwd_a)
  );

  hazard_fwd_unit u_fwd_b (
    .ra_e(hz.RA2E), .wa_m(hz.WA3M), .wa_w(hz.WA3W),
    .reg_write_m(hz.RegWriteM), .reg_write_w(hz.RegWriteW), .sel(fwd_b)
  );

  assign lds      = hz.MemtoRegE && ((hz.RA1D == hz.WA3E) || (hz.RA2D == hz.WA3E));
  assign pcp      = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;
  assign kill_lds = lds && !hz.BranchTakenE;

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    mem_err_n  = mem_err;
    stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
    flush_d = 1'b0; flush_e = 1'b0; flush_w = 1'b0;

    unique case (state)
      RUN: begin
        if (hz.MemReqM && !hz.MemReadyM) begin
          // Freeze from the very cycle the miss is seen.
          state_n    = MEM_WAIT;
          wait_cnt_n = '0;
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          flush_w    = 1'b1;
        end else begin
          stall_f = kill_lds || pcp;
          stall_d = kill_lds;
          flush_d = pcp || hz.PCSrcW || hz.BranchTakenE;
          flush_e = lds || hz.BranchTakenE;
        end
      end
      MEM_WAIT: begin
        if (hz.MemReadyM) begin
          state_n    = RUN;
          wait_cnt_n = '0;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          // Abort: release the pipeline but drop the M-stage result.
          state_n    = RUN;
          wait_cnt_n = '0;
          mem_err_n  = 1'b1;
          flush_w    = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          flush_w    = 1'b1;
        end
      end
      default: state_n = RUN;
    endcase

    if (reset) begin
      stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
      flush_d = 1'b0; flush_e = 1'b0; flush_w = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      mem_err  <= mem_err_n;
    end
  end

  assign hz.ForwardAE = reset ? FWD_RF : fwd_a;
  assign hz.ForwardBE = reset ? FWD_RF : fwd_b;
  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushW    = flush_w;
  assign hz.MemErr    = mem_err;

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (stall_f && !(&StallCycles))                        StallCycles <= StallCycles + 1'b1;
      if ((flush_d || flush_e || flush_w) && !(&FlushCount)) FlushCount  <= FlushCount + 1'b1;
    end
  end
`else
  logic [31:0] unused_cnt_w;
  assign unused_cnt_w = 32'(CNT_W);
`endif

endmodule
